xor_cipher_ctrl: RTL and testbench

Sequencer for the 32-bit Galois LFSR keystream generator in the XOR cipher datapath. It seeds the LFSR, runs a fixed warm-up discard, and assembles 8-bit key bytes LSB-first. Each key byte is XORed with one input byte over a valid/ready stream. Under output backpressure it pauses the LFSR with full context save/restore, so the keystream is bit-exact and independent of stall timing.

---
 rtl/xor_cipher_pkg.sv | 18 +
 rtl/xor_cipher_outreg.sv | 34 +++
 rtl/xor_cipher_ctrl.sv | 141 ++++++++++++++
 tb/tb_xor_cipher_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types and constants for the XOR keystream cipher sequencer
package xor_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARM,
    GEN,
    HOLD,
    PRE
  } state_e;

  localparam int PREAMBLE_LEN = 2;
  localparam int KEY_W        = 8;
  localparam int LFSR_W       = 32;
  localparam int BIT_W        = $clog2(KEY_W);

endpackage

// File: rtl/xor_cipher_outreg.sv
// rtl/xor_cipher_outreg.sv - single-entry valid/ready holding register for the cipher output byte
module xor_cipher_outreg
  import xor_cipher_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [KEY_W-1:0] data_i,
  input  logic             ready_i,
  output logic [KEY_W-1:0] data_o,
  output logic             valid_o
);

  logic [KEY_W-1:0] data_q;
  logic             valid_q;

  // A load in the same cycle as ready replaces the drained byte, so valid stays high.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/xor_cipher_ctrl.sv
// rtl/xor_cipher_ctrl.sv - seeds and paces an external Galois LFSR, assembles key bytes LSB-first
// and XORs them onto the byte stream, saving LFSR context across output stalls.
module xor_cipher_ctrl
  import xor_cipher_pkg::*;
#(
  parameter int WARMUP = 64,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] taps,
  output logic              busy,
  input  logic [KEY_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [KEY_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              lfsr_en,
  output logic [LFSR_W-1:0] lfsr_i,
  output logic [LFSR_W-1:0] lfsr_taps,
  input  logic [LFSR_W-1:0] lfsr_o,
  input  logic              lfsr_k
);

  localparam int                PRE_W      = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0]  WARM_LAST  = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(KEY_W - 1);
  localparam state_e            AFTER_LOAD = (WARMUP > 0) ? WARM : GEN;

  state_e            state_q;
  logic              lfsr_en_q;
  logic              busy_q;
  logic [PRE_W-1:0]  pre_cnt_q;
  logic [CNT_W-1:0]  warm_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [KEY_W-1:0]  key_q;
  logic [LFSR_W-1:0] seed_q;
  logic [LFSR_W-1:0] taps_q;
  logic [LFSR_W-1:0] ctx_q;

  logic in_preamble;
  logic pre_cycle_a;
  logic din_hs;

  assign in_preamble = (state_q == LOAD) || (state_q == PRE);
  assign pre_cycle_a = in_preamble && (pre_cnt_q == '0);
  assign din_ready   = (state_q == HOLD) && (!dout_valid || dout_ready);
  assign din_hs      = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= IDLE;
      lfsr_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      pre_cnt_q  <= '0;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      key_q      <= '0;
      ctx_q      <= '0;
      if (rst) begin
        seed_q <= '0;
        taps_q <= '0;
      end
    end else begin
      // Cycle A of a preamble is a throwaway shift; every other enabled cycle tracks the LFSR.
      if (lfsr_en_q && !pre_cycle_a) begin
        ctx_q <= lfsr_o;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            seed_q    <= seed;
            taps_q    <= taps;
            pre_cnt_q <= '0;
            lfsr_en_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD, PRE: begin
          if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_q <= '0;
            state_q   <= (state_q == LOAD) ? AFTER_LOAD : GEN;
          end else begin
            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
          end
        end
        WARM: begin
          if (warm_cnt_q == WARM_LAST) begin
            warm_cnt_q <= '0;
            state_q    <= GEN;
          end else begin
            warm_cnt_q <= warm_cnt_q + CNT_W'(1);
          end
        end
        GEN: begin
          key_q[bit_cnt_q] <= lfsr_k;
          bit_cnt_q        <= bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            lfsr_en_q <= 1'b0;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (din_hs) begin
            pre_cnt_q <= '0;
            lfsr_en_q <= 1'b1;
            state_q   <= PRE;
          end
        end
        default: begin
          lfsr_en_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign lfsr_en   = lfsr_en_q;
  assign lfsr_i    = (state_q == PRE) ? ctx_q : seed_q;
  assign lfsr_taps = taps_q;

  xor_cipher_outreg u_outreg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear),
    .load_i  (din_hs),
    .data_i  (din ^ key_q),
    .ready_i (dout_ready),
    .data_o  (dout),
    .valid_o (dout_valid)
  );

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// tb/tb_xor_cipher_ctrl.sv - directed and randomized checks of xor_cipher_ctrl against a Galois LFSR model
module tb_xor_cipher_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, clear, busy, din_valid, din_ready, dout_valid, dout_ready, lfsr_en, lfsr_k;
  logic [7:0]  din       [2];
  logic [7:0]  dout      [2];
  logic [31:0] seed      [2];
  logic [31:0] taps      [2];
  logic [31:0] lfsr_i    [2];
  logic [31:0] lfsr_taps [2];
  logic [31:0] lfsr_o    [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] ks_s, ks_t;

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] gstep(input logic [31:0] s, input logic [31:0] t);
    return (s >> 1) ^ (s[0] ? t : 32'h0);
  endfunction

  // Instance 0 runs without warm-up, instance 1 discards 24 bits.
  for (genvar g = 0; g < 2; g++) begin : inst
    xor_cipher_ctrl #(.WARMUP(g == 0 ? 0 : 24), .CNT_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .clear      (clear[g]),
      .seed       (seed[g]),
      .taps       (taps[g]),
      .busy       (busy[g]),
      .din        (din[g]),
      .din_valid  (din_valid[g]),
      .din_ready  (din_ready[g]),
      .dout       (dout[g]),
      .dout_valid (dout_valid[g]),
      .dout_ready (dout_ready[g]),
      .lfsr_en    (lfsr_en[g]),
      .lfsr_i     (lfsr_i[g]),
      .lfsr_taps  (lfsr_taps[g]),
      .lfsr_o     (lfsr_o[g]),
      .lfsr_k     (lfsr_k[g])
    );

    logic [31:0] m_reg = 32'h0;
    logic [1:0]  m_ph  = 2'd0;

    always @(posedge clk) begin
      if (!lfsr_en[g]) m_ph <= 2'd0;
      else if (m_ph != 2'd2) m_ph <= m_ph + 2'd1;
      if (lfsr_en[g]) m_reg <= (m_ph == 2'd1) ? lfsr_i[g] : gstep(m_reg, lfsr_taps[g]);
    end

    assign lfsr_o[g] = (lfsr_en[g] && m_ph == 2'd1) ? lfsr_i[g] : gstep(m_reg, lfsr_taps[g]);
    assign lfsr_k[g] = m_reg[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_key(output logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      k[i] = ks_s[0];
      ks_s = gstep(ks_s, ks_t);
    end
  endtask

  task automatic pulse_start(input int g, input logic [31:0] s, input logic [31:0] t);
    seed[g] = s; taps[g] = t; start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    #1;
  endtask

  task automatic pulse_clear(input int g);
    clear[g] = 1'b1;
    @(negedge clk);
    clear[g] = 1'b0;
    #1;
  endtask

  task automatic wait_ready(input int g, input string tag);
    int n = 0;
    while (!din_ready[g] && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "/din_ready"}, {31'h0, din_ready[g]}, 32'h1);
  endtask

  task automatic xfer(input int g, input logic [7:0] b, input logic [7:0] exp, input string tag);
    din[g] = b; din_valid[g] = 1'b1;
    #1;
    wait_ready(g, tag);
    @(negedge clk);
    din_valid[g] = 1'b0;
    #1;
    chk({tag, "/dout_valid"}, {31'h0, dout_valid[g]}, 32'h1);
    chk({tag, "/dout"}, {24'h0, dout[g]}, {24'h0, exp});
  endtask

  initial begin
    int n, sent, rcv, cyc;
    logic [7:0] k;
    logic [31:0] rs, rt;
    logic [7:0] expq[$];

    rst = 1'b1; start = '0; clear = '0; din_valid = '0; dout_ready = '0;
    for (int g = 0; g < 2; g++) begin din[g] = '0; seed[g] = '0; taps[g] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset/busy",       {30'h0, busy},       32'h0);
    chk("reset/lfsr_en",    {30'h0, lfsr_en},    32'h0);
    chk("reset/din_ready",  {30'h0, din_ready},  32'h0);
    chk("reset/dout_valid", {30'h0, dout_valid}, 32'h0);
    chk("reset/dout0",      {24'h0, dout[0]},    32'h0);

    // Scenario 1: key bytes 01,00,00,00,01 with no warm-up.
    dout_ready[0] = 1'b1;
    pulse_start(0, 32'h1, 32'h8000_0000);
    chk("t1/busy",    {31'h0, busy[0]},    32'h1);
    chk("t1/lfsr_en", {31'h0, lfsr_en[0]}, 32'h1);
    xfer(0, 8'hA5, 8'hA4, "t1b0");
    xfer(0, 8'h3C, 8'h3C, "t1b1");
    xfer(0, 8'h11, 8'h11, "t1b2");
    xfer(0, 8'h22, 8'h22, "t1b3");
    xfer(0, 8'h5A, 8'h5B, "t1b4");

    // Scenario 2: 24-bit warm-up, first din_ready 35 cycles after start.
    dout_ready[1] = 1'b1;
    pulse_start(1, 32'h1, 32'h8000_0000);
    n = 1;
    while (!din_ready[1] && n < 200) begin @(negedge clk); #1; n++; end
    chk("t2/latency", n, 35);
    xfer(1, 8'h5A, 8'h5A, "t2b0");
    xfer(1, 8'h0F, 8'h0E, "t2b1");

    // Scenario 3: restart, then 20 cycles of output backpressure before byte 1.
    pulse_clear(0);
    pulse_start(0, 32'h1, 32'h8000_0000);
    xfer(0, 8'hA5, 8'hA4, "t3b0");
    dout_ready[0] = 1'b0;
    din[0] = 8'h3C; din_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("t3/stall din_ready", {31'h0, din_ready[0]}, 32'h0);
      chk("t3/stall dout",      {24'h0, dout[0]},      32'hA4);
    end
    chk("t3/stall dout_valid", {31'h0, dout_valid[0]}, 32'h1);
    dout_ready[0] = 1'b1;
    xfer(0, 8'h3C, 8'h3C, "t3b1");
    xfer(0, 8'h11, 8'h11, "t3b2");
    xfer(0, 8'h22, 8'h22, "t3b3");
    xfer(0, 8'h5A, 8'h5B, "t3b4");

    // Scenario 4: clear beats start, clear mid-GEN, then a fresh reseed.
    seed[0] = 32'h1; taps[0] = 32'h8000_0000;
    clear[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0; start[0] = 1'b0;
    #1;
    chk("t4/clear+start busy", {31'h0, busy[0]}, 32'h0);
    pulse_start(0, 32'h1, 32'h8000_0000);
    chk("t4/preamble lfsr_en", {31'h0, lfsr_en[0]}, 32'h1);
    chk("t4/preamble lfsr_i",  lfsr_i[0],           32'h1);
    repeat (4) begin @(negedge clk); #1; end
    pulse_clear(0);
    chk("t4/clear lfsr_en",    {31'h0, lfsr_en[0]},    32'h0);
    chk("t4/clear busy",       {31'h0, busy[0]},       32'h0);
    chk("t4/clear dout_valid", {31'h0, dout_valid[0]}, 32'h0);
    pulse_start(0, 32'h1, 32'h8000_0000);
    chk("t4/restart lfsr_en",  {31'h0, lfsr_en[0]},    32'h1);
    xfer(0, 8'h77, 8'h76, "t4b0");

    // Scenario 5: start ignored in WARM and HOLD, then rst while in HOLD.
    pulse_clear(1);
    pulse_start(1, 32'h1, 32'h8000_0000);
    repeat (10) begin @(negedge clk); #1; end
    pulse_start(1, 32'hDEAD_BEEF, 32'h0000_1234);
    chk("t5/warm start taps", lfsr_taps[1], 32'h8000_0000);
    xfer(1, 8'h5A, 8'h5A, "t5b0");
    wait_ready(1, "t5/hold");
    pulse_start(1, 32'hDEAD_BEEF, 32'h0000_0001);
    chk("t5/hold start busy", {31'h0, busy[1]}, 32'h1);
    chk("t5/hold start taps", lfsr_taps[1],     32'h8000_0000);
    xfer(1, 8'h0F, 8'h0E, "t5b1");
    wait_ready(1, "t5/hold2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5/rst busy",       {31'h0, busy[1]},       32'h0);
    chk("t5/rst lfsr_en",    {31'h0, lfsr_en[1]},    32'h0);
    chk("t5/rst din_ready",  {31'h0, din_ready[1]},  32'h0);
    chk("t5/rst dout_valid", {31'h0, dout_valid[1]}, 32'h0);
    chk("t5/rst dout",       {24'h0, dout[1]},       32'h0);
    chk("t5/rst taps",       lfsr_taps[1],           32'h0);

    // Scenario 6: random seed/taps, 1000 bytes, random stalls on both sides.
    rs = $urandom | 32'h1;
    rt = $urandom | 32'h8000_0000;
    ks_s = rs; ks_t = rt;
    for (int i = 0; i < 3; i++) next_key(k);
    din_valid[1] = 1'b0; dout_ready[1] = 1'b0;
    pulse_start(1, rs, rt);
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 1000 && cyc < 60000) begin
      din[1]        = 8'($urandom);
      din_valid[1]  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      dout_ready[1] = ($urandom_range(0, 9) < 6);
      #1;
      if (dout_valid[1] && dout_ready[1]) begin
        if (expq.size() > 0) chk("t6/dout", {24'h0, dout[1]}, {24'h0, expq.pop_front()});
        else chk("t6/unexpected dout_valid", {31'h0, dout_valid[1]}, 32'h0);
        rcv++;
      end
      if (din_valid[1] && din_ready[1]) begin
        next_key(k);
        expq.push_back(din[1] ^ k);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("t6/bytes received", rcv, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
